mdu: RTL and testbench

Iterative multiply/divide unit: the multi-cycle successor to the single-cycle `alu`, implementing the full RISC-V M-extension operation set over a parametrised data width. Operands enter through a valid/ready request port. Results leave through a valid/ready response port. The unit computes one bit per cycle using radix-2 shift-add multiplication and restoring division. It sits beside `alu` in the execute stage; the core stalls on `in_ready`/`out_valid`.

---
 rtl/mdu.sv | 210 +++++++++++++++++++++
 tb/tb_mdu.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Iterative RISC-V M-extension multiply/divide unit with a radix-2 shift-add multiplier and a restoring divider.
// Define MDU_DIV_EN to build the divide datapath; without it, ops 100-111 return 0 one cycle after acceptance.
module mdu #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam int unsigned AW = 2 * XLEN;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    // Multiply: {product_hi, multiplier}. Divide: {remainder, dividend/quotient}.
    logic [AW-1:0]   acc, acc_nxt;
    logic [XLEN-1:0] opnd, opnd_nxt;
    logic            mul_hi, mul_hi_nxt;
    logic            neg_res, neg_res_nxt;
    logic            special, special_nxt;
    logic [XLEN-1:0] result_nxt;

    logic            a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN:0]   sum;
    logic [AW-1:0]   prod;

`ifdef MDU_DIV_EN
    logic            is_div, is_div_nxt;
    logic            is_rem, is_rem_nxt;
    logic            neg_rem, neg_rem_nxt;
    logic [XLEN:0]   rem_sh, diff;
    logic [XLEN-1:0] quo_fix, rem_fix;
`endif

    // State and datapath registers; status outputs follow the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            opnd      <= '0;
            mul_hi    <= 1'b0;
            neg_res   <= 1'b0;
            special   <= 1'b0;
            result    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef MDU_DIV_EN
            is_div    <= 1'b0;
            is_rem    <= 1'b0;
            neg_rem   <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            acc       <= acc_nxt;
            opnd      <= opnd_nxt;
            mul_hi    <= mul_hi_nxt;
            neg_res   <= neg_res_nxt;
            special   <= special_nxt;
            result    <= result_nxt;
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
            busy      <= (state_nxt != IDLE);
`ifdef MDU_DIV_EN
            is_div    <= is_div_nxt;
            is_rem    <= is_rem_nxt;
            neg_rem   <= neg_rem_nxt;
`endif
        end
    end

    // Next-state, operand capture, iteration step and sign fix-up.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        acc_nxt     = acc;
        opnd_nxt    = opnd;
        mul_hi_nxt  = mul_hi;
        neg_res_nxt = neg_res;
        special_nxt = special;
        result_nxt  = result;
        a_sgn       = 1'b0;
        b_sgn       = 1'b0;
        a_neg       = 1'b0;
        b_neg       = 1'b0;
        mag_a       = a;
        mag_b       = b;
        sum         = '0;
        prod        = '0;
`ifdef MDU_DIV_EN
        is_div_nxt  = is_div;
        is_rem_nxt  = is_rem;
        neg_rem_nxt = neg_rem;
        rem_sh      = '0;
        diff        = '0;
        quo_fix     = '0;
        rem_fix     = '0;
`endif

        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    a_sgn       = op[2] ? !op[0] : (op[1:0] != 2'b11);
                    b_sgn       = op[2] ? !op[0] : !op[1];
                    a_neg       = a_sgn & a[XLEN-1];
                    b_neg       = b_sgn & b[XLEN-1];
                    mag_a       = a_neg ? -a : a;
                    mag_b       = b_neg ? -b : b;
                    state_nxt   = CALC;
                    cnt_nxt     = '0;
                    special_nxt = 1'b0;
                    mul_hi_nxt  = (op[1:0] != 2'b00);
                    neg_res_nxt = a_neg ^ b_neg;
                    if (!op[2]) begin
                        opnd_nxt = mag_a;
                        acc_nxt  = {XLEN'(0), mag_b};
                    end else begin
`ifdef MDU_DIV_EN
                        is_div_nxt  = 1'b1;
                        is_rem_nxt  = op[1];
                        neg_rem_nxt = a_neg;
                        opnd_nxt    = mag_b;
                        acc_nxt     = {XLEN'(0), mag_a};
                        if (b == '0) begin
                            special_nxt = 1'b1;
                            acc_nxt     = {XLEN'(0), (op[1] ? a : {XLEN{1'b1}})};
                        end else if (!op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1)) begin
                            special_nxt = 1'b1;
                            acc_nxt     = {XLEN'(0), (op[1] ? XLEN'(0) : a)};
                        end
`else
                        special_nxt = 1'b1;
                        acc_nxt     = '0;
`endif
                    end
`ifdef MDU_DIV_EN
                    if (!op[2]) begin
                        is_div_nxt = 1'b0;
                    end
`endif
                end
            end

            CALC: begin
                if (special) begin
                    result_nxt = acc[XLEN-1:0];
                    state_nxt  = DONE;
                end else if (cnt == CW'(XLEN)) begin
                    state_nxt = DONE;
                    prod      = neg_res ? -acc : acc;
                    result_nxt = mul_hi ? prod[AW-1:XLEN] : prod[XLEN-1:0];
`ifdef MDU_DIV_EN
                    if (is_div) begin
                        quo_fix    = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
                        rem_fix    = neg_rem ? -acc[AW-1:XLEN] : acc[AW-1:XLEN];
                        result_nxt = is_rem ? rem_fix : quo_fix;
                    end
`endif
                end else begin
                    cnt_nxt = cnt + CW'(1);
`ifdef MDU_DIV_EN
                    if (is_div) begin
                        // Restoring step: shift in the next dividend bit, keep the difference if no borrow.
                        rem_sh = {acc[AW-1:XLEN], acc[XLEN-1]};
                        diff   = rem_sh - {1'b0, opnd};
                        if (!diff[XLEN]) begin
                            acc_nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
                        end else begin
                            acc_nxt = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        sum     = {1'b0, acc[AW-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
                        acc_nxt = {sum, acc[XLEN-1:1]};
                    end
`else
                    sum     = {1'b0, acc[AW-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
                    acc_nxt = {sum, acc[XLEN-1:1]};
`endif
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu (XLEN=32): directed M-extension cases plus randomized ops against an arithmetic reference.
module tb_mdu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int n_checks;
    int n_fail;

    mdu #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result straight from RISC-V M-extension arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy, sp, sq;
        logic [63:0]        ux, uy, up;
        logic [31:0]        r;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'd0, x};
        uy = {32'd0, y};
        r  = '0;
        case (o)
            3'b000: begin sp = sx * sy;          r = sp[31:0];  end
            3'b001: begin sp = sx * sy;          r = sp[63:32]; end
            3'b010: begin sp = sx * $signed(uy); r = sp[63:32]; end
            3'b011: begin up = ux * uy;          r = up[63:32]; end
            3'b100: begin
                if (y == 32'd0) r = 32'hFFFF_FFFF;
                else begin sq = sx / sy; r = sq[31:0]; end
            end
            3'b101: begin
                if (y == 32'd0) r = 32'hFFFF_FFFF;
                else begin up = ux / uy; r = up[31:0]; end
            end
            3'b110: begin
                if (y == 32'd0) r = x;
                else begin sq = sx % sy; r = sq[31:0]; end
            end
            default: begin
                if (y == 32'd0) r = x;
                else begin up = ux % uy; r = up[31:0]; end
            end
        endcase
`ifndef MDU_DIV_EN
        if (o[2]) r = '0;
`endif
        return r;
    endfunction

    // Cycles from acceptance to out_valid.
    function automatic int ref_latency(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
`ifdef MDU_DIV_EN
        if (o[2] && (y == 32'd0)) return 1;
        if ((o == 3'b100 || o == 3'b110) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return 33;
`else
        if (o[2]) return 1;
        return 33;
`endif
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 9))
            0: v = 32'd0;
            1: v = 32'd1;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h8000_0000;
            4: v = 32'h7FFF_FFFF;
            5: v = 32'($urandom_range(0, 15));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Drives one request, waits for out_valid, and optionally observes the cycle after the handshake.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic ordy,
                          output logic [31:0] res, output int lat, output logic ov_after,
                          output logic ir_after, output logic overlap);
        int w;
        overlap  = 1'b0;
        ov_after = 1'b0;
        ir_after = 1'b0;
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1; out_ready = ordy;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) overlap = 1'b1;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (in_ready && out_valid) overlap = 1'b1;
        res = result;
        if (ordy) begin
            @(posedge clk);
            @(negedge clk);
            ov_after = out_valid;
            ir_after = in_ready;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", result); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_mul_basic();
        logic [31:0] res; int lat; logic ova, ira, ovl;
        run_op(3'b000, 32'd6, 32'd7, 1'b1, res, lat, ova, ira, ovl);
        n_checks++; if (res !== 32'd42) begin n_fail++; $display("FAIL mul_6x7 got=%h exp=%h", res, 32'd42); end
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL mul_latency got=%0d exp=33", lat); end
        n_checks++; if (ova !== 1'b0) begin n_fail++; $display("FAIL mul_valid_width out_valid_after=%b exp=0", ova); end
        n_checks++; if (ira !== 1'b1) begin n_fail++; $display("FAIL mul_ready_after got=%b exp=1", ira); end
        n_checks++; if (ovl !== 1'b0) begin n_fail++; $display("FAIL mul_ready_valid_overlap got=%b exp=0", ovl); end
    endtask

    task automatic test_high_mul();
        logic [2:0]  ops [4] = '{3'b001, 3'b011, 3'b010, 3'b000};
        logic [31:0] exps[4] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        logic [31:0] res; int lat; logic ova, ira, ovl;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, res, lat, ova, ira, ovl);
            n_checks++;
            if (res !== exps[i]) begin n_fail++; $display("FAIL high_mul op=%b got=%h exp=%h", ops[i], res, exps[i]); end
            n_checks++;
            if (lat !== 33) begin n_fail++; $display("FAIL high_mul_latency op=%b got=%0d exp=33", ops[i], lat); end
        end
    endtask

    task automatic test_divide();
        logic [2:0]  ops[8] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b110};
        logic [31:0] as [8] = '{-32'sd7, -32'sd7, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs [8] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] res, exp_r; int lat, exp_l; logic ova, ira, ovl;
        for (int i = 0; i < 8; i++) begin
            exp_r = ref_result(ops[i], as[i], bs[i]);
            exp_l = ref_latency(ops[i], as[i], bs[i]);
            run_op(ops[i], as[i], bs[i], 1'b1, res, lat, ova, ira, ovl);
            n_checks++;
            if (res !== exp_r) begin n_fail++; $display("FAIL divide op=%b a=%h b=%h got=%h exp=%h", ops[i], as[i], bs[i], res, exp_r); end
            n_checks++;
            if (lat !== exp_l) begin n_fail++; $display("FAIL divide_latency op=%b got=%0d exp=%0d", ops[i], lat, exp_l); end
            n_checks++;
            if (ova !== 1'b0 || ira !== 1'b1) begin n_fail++; $display("FAIL divide_release out_valid=%b in_ready=%b exp=0/1", ova, ira); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] res; int lat; logic ova, ira, ovl; int bad;
        run_op(3'b000, 32'd3, 32'd5, 1'b0, res, lat, ova, ira, ovl);
        n_checks++; if (res !== 32'd15) begin n_fail++; $display("FAIL bp_result got=%h exp=%h", res, 32'd15); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; op = 3'b000; a = 32'd9; b = 32'd9;
            @(posedge clk);
            @(negedge clk);
            if (result !== 32'd15 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bp_hold bad_cycles=%0d exp=0", bad); end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release in_ready=%b out_valid=%b exp=1/0", in_ready, out_valid); end
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bp_ignored_request out_valid_cycles=%0d exp=0", bad); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res; int lat; logic ova, ira, ovl; int seen;
        @(negedge clk);
`ifdef MDU_DIV_EN
        op = 3'b101;
`else
        op = 3'b000;
`endif
        a = 32'd1000; b = 32'd3; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs in_ready=%b out_valid=%b busy=%b result=%h exp=1/0/0/0", in_ready, out_valid, busy, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL mid_reset_no_result out_valid_cycles=%0d exp=0", seen); end
        run_op(3'b000, 32'd2, 32'd3, 1'b1, res, lat, ova, ira, ovl);
        n_checks++; if (res !== 32'd6) begin n_fail++; $display("FAIL mid_reset_mul got=%h exp=%h", res, 32'd6); end
        run_op(3'b100, 32'd8, 32'd2, 1'b1, res, lat, ova, ira, ovl);
        n_checks++;
        if (res !== ref_result(3'b100, 32'd8, 32'd2)) begin n_fail++; $display("FAIL div_8_2 got=%h exp=%h", res, ref_result(3'b100, 32'd8, 32'd2)); end
        n_checks++;
        if (lat !== ref_latency(3'b100, 32'd8, 32'd2)) begin n_fail++; $display("FAIL div_8_2_latency got=%0d exp=%0d", lat, ref_latency(3'b100, 32'd8, 32'd2)); end
    endtask

    task automatic test_random();
        logic [2:0] o; logic [31:0] x, y, res, exp_r; int lat, exp_l; logic ova, ira, ovl;
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            x = pick_operand();
            y = pick_operand();
            exp_r = ref_result(o, x, y);
            exp_l = ref_latency(o, x, y);
            run_op(o, x, y, 1'b1, res, lat, ova, ira, ovl);
            n_checks++;
            if (res !== exp_r) begin n_fail++; $display("FAIL random op=%b a=%h b=%h got=%h exp=%h", o, x, y, res, exp_r); end
            n_checks++;
            if (lat !== exp_l || ova !== 1'b0 || ovl !== 1'b0) begin
                n_fail++;
                $display("FAIL random_timing op=%b latency=%0d exp=%0d out_valid_after=%b overlap=%b", o, lat, exp_l, ova, ovl);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_mul_basic();
        test_high_mul();
        test_divide();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
